// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and encodings for the arrow scheduling logic
package ddr_pkg;
  typedef enum logic [1:0] {IDLE, GATHER, HOLD, ISSUE} state_t;
  typedef logic [3:0] lane_mask_t;
  localparam logic [1:0] LANE_LEFT = 2'd0;
  localparam logic [1:0] LANE_DOWN = 2'd1;
  localparam logic [1:0] LANE_UP = 2'd2;
  localparam logic [1:0] LANE_RIGHT = 2'd3;
  localparam logic [1:0] LVL_EASY = 2'd0;
  localparam logic [1:0] LVL_NORMAL = 2'd1;
  localparam logic [1:0] LVL_HARD = 2'd2;
  localparam logic [1:0] LVL_EXPERT = 2'd3;
  function automatic lane_mask_t lane_bit(input logic [1:0] l);
    lane_bit = (l == LANE_DOWN) ? 4'b0010 : (l == LANE_UP) ? 4'b0100 : (l == LANE_RIGHT) ? 4'b1000 : 4'b0001;
  endfunction
endpackage

// File: rtl/beat_timer.sv
// beat_timer: free-running BEAT_DIV divider with synchronous clear and one-cycle beat pulse
module beat_timer #(
  parameter int BEAT_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic beat_o
);
  localparam int CW = $clog2(BEAT_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (clr_i || cnt_q == CW'(BEAT_DIV - 1)) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign beat_o = cnt_q == CW'(BEAT_DIV - 1);
endmodule

// File: rtl/arrow_scheduler.sv
// arrow_scheduler: gathers random bits into lane masks and offers one spawn per beat
module arrow_scheduler
  import ddr_pkg::*;
#(
  parameter int BEAT_DIV = 25_000_000,
  parameter int SKIP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rand_bit,
  input  logic [1:0]        level,
  output logic              spawn_valid,
  output lane_mask_t        spawn_lanes,
  input  logic              spawn_ready,
  output logic              beat,
  output logic [SKIP_W-1:0] skipped
);
  state_t state_q, state_d;
  logic [3:0] r_q, r_d, r_new;
  logic [1:0] bcnt_q, bcnt_d;
  lane_mask_t mask_q, mask_d, mask_new;
  logic [1:0] lane_q, lane_d, h1_q, h1_d, h2_q, h2_d, hv_q, hv_d;
  logic [1:0] lane_adj, lane_dbl;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic emit, dbl;
  beat_timer #(.BEAT_DIV(BEAT_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (!enable || state_q == IDLE),
    .beat_o(beat)
  );
  assign r_new = {rand_bit, r_q[3:1]};
  // a lane repeated on both of the last two spawns is nudged to the next lane
  assign lane_adj = (hv_q == 2'b11 && r_new[1:0] == h1_q && r_new[1:0] == h2_q) ? r_new[1:0] + 2'd1 : r_new[1:0];
  assign lane_dbl = lane_adj + 2'd2;
  assign emit = (level == LVL_EASY) ? &r_new[3:2] : (level == LVL_NORMAL) ? r_new[3] : (level == LVL_HARD) ? |r_new[3:2] : 1'b1;
  assign dbl = level == LVL_EXPERT && &r_new[3:2];
  assign mask_new = emit ? (lane_bit(lane_adj) | (dbl ? lane_bit(lane_dbl) : 4'b0000)) : 4'b0000;
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    bcnt_d = bcnt_q;
    mask_d = mask_q;
    lane_d = lane_q;
    h1_d = h1_q;
    h2_d = h2_q;
    hv_d = hv_q;
    skip_d = (state_q == ISSUE && beat && !spawn_ready && !(&skip_q)) ? skip_q + 1'b1 : skip_q;
    if (!enable) begin
      state_d = IDLE;
      r_d = '0;
      bcnt_d = '0;
      mask_d = '0;
      h1_d = LANE_LEFT;
      h2_d = LANE_LEFT;
      hv_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = GATHER;
        GATHER: begin
          r_d = r_new;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = HOLD;
            lane_d = lane_adj;
            mask_d = mask_new;
          end
        end
        HOLD: state_d = beat ? ((|mask_q) ? ISSUE : GATHER) : HOLD;
        ISSUE: if (spawn_ready) begin
          state_d = GATHER;
          h1_d = lane_q;
          h2_d = h1_q;
          hv_d = {hv_q[0], 1'b1};
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      r_q <= '0;
      bcnt_q <= '0;
      mask_q <= '0;
      lane_q <= LANE_LEFT;
      h1_q <= LANE_LEFT;
      h2_q <= LANE_LEFT;
      hv_q <= '0;
      skip_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      bcnt_q <= bcnt_d;
      mask_q <= mask_d;
      lane_q <= lane_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
      hv_q <= hv_d;
      skip_q <= skip_d;
    end
  assign spawn_valid = state_q == ISSUE;
  assign spawn_lanes = spawn_valid ? mask_q : 4'b0000;
  assign skipped = skip_q;
endmodule
